alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream issue stage for the ALU. Accepts one operation at a time from the decode stage over a valid/ready handshake.
//  Screens illegal opcodes and divide-by-zero, drives the ALU until it asserts done, or aborts on timeout.
//  Captures result and flags, keeps the architectural Z/N/C/V flag register, and presents a response to writeback.
//  Only one operation is in flight at any time.
// PARAMETERS
//  DATA_W      16  operand/result width (matches ALU term1/term2/result)
//  DST_W       3   destination register index width
//  TIMEOUT     16  max cycles in EXEC waiting for alu_done before abort (>=2)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_b        in   1       reset; one clock; reset is asynchronous and active-high (1 = reset)
//  req_valid    in   1       request present
//  req_ready    out  1       stage can accept (high only in IDLE)
//  req_opcode   in   6       ALU opcode 0..17 (ADD..DEC encoding of the ALU)
//  req_dst      in   DST_W   destination register
//  req_op1      in   DATA_W  operand -> term1
//  req_op2      in   DATA_W  operand -> term2
//  alu_enable   out  1       ALU enable, high throughout EXEC
//  alu_opcode   out  6       latched opcode to ALU
//  alu_term1    out  DATA_W  latched op1
//  alu_term2    out  DATA_W  latched op2
//  alu_result   in   DATA_W  ALU result
//  alu_fl_zero/alu_fl_negative/alu_fl_carry/alu_fl_overflow  in  1 each  ALU flags
//  alu_done     in   1       ALU completion
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       writeback accepts
//  rsp_result   out  DATA_W  captured result (0 on error)
//  rsp_dst      out  DST_W   echoed destination
//  rsp_wb_en    out  1       1 = write rsp_result to rsp_dst
//  rsp_error    out  2       00 ok, 01 illegal opcode, 10 div/mod by zero, 11 timeout
//  flags        out  4       architectural {Z,N,C,V}
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0 except req_ready=1, flags=4'b0000, timeout counter 0; async assert, sync-safe release.
//  Reset mid-operation: transaction discarded, alu_enable drops immediately, no response produced.
//  FSM IDLE -> EXEC | RESP; EXEC -> RESP; RESP -> IDLE.
//  IDLE: req_ready=1. On req_valid: latch opcode/dst/op1/op2.
//   opcode>17 -> RESP, err 01.
//   opcode 3/4 with op2==0 -> RESP, err 10.
//   Otherwise -> EXEC, counter cleared.
//   Error paths never raise alu_enable.
//  EXEC: alu_enable=1; alu_opcode/terms stable from latch; counter +1 per cycle.
//   alu_done==1: capture result+flags, -> RESP, err 00 (done wins over timeout in the same cycle).
//   Counter==TIMEOUT-1 without done: -> RESP, err 11, result 0.
//  RESP: rsp_valid=1; all rsp_* held stable until rsp_ready; handshake -> IDLE. alu_enable=0.
//  rsp_wb_en=1 only for err 00 and opcode not CMP(9)/TST(15); CMP/TST update flags only.
//  flags updated from ALU flags on EXEC->RESP with err 00; unchanged on any error.
//  alu_done outside EXEC ignored. req_* ignored unless IDLE.
//  Latency: accept at cycle 0, alu_enable at cycle 1, done sampled at cycle k, rsp_valid at k+1; error paths rsp_valid at 1.
//  Throughput: accepted req -> next req_ready no earlier than cycle after rsp handshake.
// TESTING
//  1. ADD 5+10, dst=2, ALU done after 1 cycle -> rsp_result=15, wb_en=1, dst=2, err 00, flags=0000, alu_enable high exactly 1 cycle.
//  2. CMP 0x30,0x20 -> wb_en=0, err 00, flags follow ALU; then SUB 0x10-0x0A -> rsp_result=6, wb_en=1.
//  3. opcode 6'd20 -> rsp_valid at cycle 1, err 01, alu_enable never high, flags unchanged.
//  4. DIV 0x1E/0 -> err 10, no ALU activity; DIV 0x1E/3 -> rsp_result=10.
//  5. TIMEOUT=16, alu_done held 0 -> alu_enable high 16 cycles, then err 11, result 0, flags unchanged.
//  6. rsp_ready low 5 cycles -> rsp_* stable, req_ready=0; rst_b pulse during EXEC -> outputs 0, IDLE.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the ALU: screens requests, runs the ALU under a
// timeout, keeps the architectural Z/N/C/V flags and returns one response per request.
module alu_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter int DST_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_b,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [DST_W-1:0]  req_dst,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,

  output logic              alu_enable,
  output logic [5:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_term1,
  output logic [DATA_W-1:0] alu_term2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_fl_zero,
  input  logic              alu_fl_negative,
  input  logic              alu_fl_carry,
  input  logic              alu_fl_overflow,
  input  logic              alu_done,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DST_W-1:0]  rsp_dst,
  output logic              rsp_wb_en,
  output logic [1:0]        rsp_error,
  output logic [3:0]        flags
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0] OP_DIV  = 6'd3;
  localparam logic [5:0] OP_MOD  = 6'd4;
  localparam logic [5:0] OP_CMP  = 6'd9;
  localparam logic [5:0] OP_TST  = 6'd15;
  localparam logic [5:0] OP_LAST = 6'd17;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIVZERO = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic                req_ready_q;
  logic                alu_enable_q;
  logic [5:0]          opcode_q;
  logic [DATA_W-1:0]   term1_q;
  logic [DATA_W-1:0]   term2_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic [DST_W-1:0]    rsp_dst_q;
  logic                rsp_wb_en_q;
  logic [1:0]          rsp_error_q;
  logic [3:0]          flags_q;

  logic                illegal_op;
  logic                div_by_zero;
  logic                writes_reg;
  logic                timed_out;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    illegal_op  = 1'b0;
    div_by_zero = 1'b0;
    writes_reg  = 1'b1;
    timed_out   = 1'b0;
    if (req_opcode > OP_LAST) illegal_op = 1'b1;
    if ((req_opcode == OP_DIV || req_opcode == OP_MOD) && req_op2 == '0) div_by_zero = 1'b1;
    if (opcode_q == OP_CMP || opcode_q == OP_TST) writes_reg = 1'b0;
    if (cnt_q == CNT_W'(TIMEOUT - 1)) timed_out = 1'b1;
  end

  // Whole controller in one registered process so every output is a flop.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      alu_enable_q <= 1'b0;
      opcode_q     <= '0;
      term1_q      <= '0;
      term2_q      <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_dst_q    <= '0;
      rsp_wb_en_q  <= 1'b0;
      rsp_error_q  <= ERR_OK;
      flags_q      <= 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            opcode_q    <= req_opcode;
            term1_q     <= req_op1;
            term2_q     <= req_op2;
            rsp_dst_q   <= req_dst;
            req_ready_q <= 1'b0;
            if (illegal_op || div_by_zero) begin
              // Screened requests answer directly and never touch the ALU.
              state_q      <= ST_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_result_q <= '0;
              rsp_wb_en_q  <= 1'b0;
              rsp_error_q  <= illegal_op ? ERR_ILLEGAL : ERR_DIVZERO;
            end else begin
              state_q      <= ST_EXEC;
              alu_enable_q <= 1'b1;
              cnt_q        <= '0;
            end
          end
        end

        ST_EXEC: begin
          cnt_q <= cnt_q + 1'b1;
          if (alu_done) begin
            state_q      <= ST_RESP;
            alu_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_wb_en_q  <= writes_reg;
            rsp_error_q  <= ERR_OK;
            flags_q      <= {alu_fl_zero, alu_fl_negative, alu_fl_carry, alu_fl_overflow};
          end else if (timed_out) begin
            state_q      <= ST_RESP;
            alu_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= '0;
            rsp_wb_en_q  <= 1'b0;
            rsp_error_q  <= ERR_TIMEOUT;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          alu_enable_q <= 1'b0;
          rsp_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_enable = alu_enable_q;
  assign alu_opcode = opcode_q;
  assign alu_term1  = term1_q;
  assign alu_term2  = term2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_dst    = rsp_dst_q;
  assign rsp_wb_en  = rsp_wb_en_q;
  assign rsp_error  = rsp_error_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed requests, the bench plays the ALU, and a
// scoreboard monitor compares every response handshake against queued expectations.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [2:0]  req_dst;
  logic [15:0] req_op1;
  logic [15:0] req_op2;
  logic        alu_enable;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_term1;
  logic [15:0] alu_term2;
  logic [15:0] alu_result;
  logic        alu_fl_zero;
  logic        alu_fl_negative;
  logic        alu_fl_carry;
  logic        alu_fl_overflow;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_dst;
  logic        rsp_wb_en;
  logic [1:0]  rsp_error;
  logic [3:0]  flags;

  typedef struct {
    logic [15:0] result;
    logic [2:0]  dst;
    logic        wb;
    logic [1:0]  err;
    logic [3:0]  flags;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_total = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(16), .DST_W(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_dst(req_dst), .req_op1(req_op1), .req_op2(req_op2),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_term1(alu_term1), .alu_term2(alu_term2), .alu_result(alu_result),
    .alu_fl_zero(alu_fl_zero), .alu_fl_negative(alu_fl_negative),
    .alu_fl_carry(alu_fl_carry), .alu_fl_overflow(alu_fl_overflow),
    .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_dst(rsp_dst), .rsp_wb_en(rsp_wb_en), .rsp_error(rsp_error),
    .flags(flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: counts ALU-enable cycles and compares each response handshake.
  task automatic monitor();
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        if (alu_enable) en_total++;
        if (rsp_valid && rsp_ready) begin
          check("sb_pending", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_result", rsp_result, e.result);
            check("rsp_dst", rsp_dst, e.dst);
            check("rsp_wb_en", rsp_wb_en, e.wb);
            check("rsp_error", rsp_error, e.err);
            check("flags", flags, e.flags);
          end
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic rsp_t mk(input logic [15:0] r, input logic [2:0] d, input logic w,
                              input logic [1:0] er, input logic [3:0] f);
    rsp_t e;
    e.result = r; e.dst = d; e.wb = w; e.err = er; e.flags = f;
    return e;
  endfunction

  // Issues one request, acts as the ALU (done on the done_at-th EXEC cycle, never if <0),
  // checks latency and ALU-enable duration, optionally stalls writeback for 'hold' cycles.
  task automatic run_op(input string nm, input logic [5:0] op, input logic [2:0] dst,
                        input logic [15:0] a, input logic [15:0] b, input int done_at,
                        input logic [15:0] ares, input logic [3:0] afl, input rsp_t e,
                        input int exp_lat, input int exp_en, input int hold);
    int lat;
    int ex;
    int en_start;
    bit seen;
    check({nm, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_opcode = op; req_dst = dst; req_op1 = a; req_op2 = b;
    next_cycle();
    req_valid = 1'b0;
    exp_q.push_back(e);
    en_start = en_total;
    lat = 1; ex = 0; seen = 1'b0;
    while (lat <= 64) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (alu_enable) begin
        ex++;
        if (ex == 1) begin
          check({nm, "_alu_opcode"}, alu_opcode, op);
          check({nm, "_alu_term1"}, alu_term1, a);
          check({nm, "_alu_term2"}, alu_term2, b);
        end
        alu_done = (ex == done_at);
        alu_result = ares;
        {alu_fl_zero, alu_fl_negative, alu_fl_carry, alu_fl_overflow} = afl;
      end else begin
        alu_done = 1'b0;
      end
      next_cycle();
      lat++;
    end
    alu_done = 1'b0;
    check({nm, "_latency"}, seen ? lat : 0, exp_lat);
    if (!seen) begin
      void'(exp_q.pop_back());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check({nm, "_hold_valid"}, rsp_valid, 1);
      check({nm, "_hold_result"}, rsp_result, e.result);
      check({nm, "_hold_err"}, rsp_error, e.err);
      check({nm, "_hold_req_ready"}, req_ready, 0);
      req_valid = 1'b1; req_opcode = 6'd20;
      next_cycle();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    next_cycle();
    rsp_ready = 1'b0;
    check({nm, "_alu_en_cycles"}, en_total - en_start, exp_en);
    check({nm, "_rsp_valid_low"}, rsp_valid, 0);
    check({nm, "_req_ready_back"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b1;
    req_valid = 1'b0; req_opcode = '0; req_dst = '0; req_op1 = '0; req_op2 = '0;
    alu_result = '0; alu_fl_zero = 1'b0; alu_fl_negative = 1'b0;
    alu_fl_carry = 1'b0; alu_fl_overflow = 1'b0; alu_done = 1'b0; rsp_ready = 1'b0;
    fork
      monitor();
    join_none
    next_cycle();
    next_cycle();
    check("reset_req_ready", req_ready, 1);
    check("reset_alu_enable", alu_enable, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_flags", flags, 0);
    rst_b = 1'b0;
    next_cycle();

    // alu_done outside EXEC must be ignored
    alu_done = 1'b1;
    repeat (3) next_cycle();
    alu_done = 1'b0;
    check("idle_done_rsp_valid", rsp_valid, 0);
    check("idle_done_req_ready", req_ready, 1);

    run_op("add",     6'd0,  3'd2, 16'd5,    16'd10,   1,  16'd15,   4'b0000, mk(16'd15,   3'd2, 1'b1, 2'b00, 4'b0000), 2,  1,  0);
    run_op("sub",     6'd1,  3'd3, 16'h10,   16'h0A,   2,  16'd6,    4'b0000, mk(16'd6,    3'd3, 1'b1, 2'b00, 4'b0000), 3,  2,  0);
    run_op("cmp",     6'd9,  3'd1, 16'h30,   16'h20,   1,  16'h10,   4'b0010, mk(16'h10,   3'd1, 1'b0, 2'b00, 4'b0010), 2,  1,  0);
    run_op("ill20",   6'd20, 3'd4, 16'd1,    16'd2,   -1,  16'd0,    4'b0000, mk(16'd0,    3'd4, 1'b0, 2'b01, 4'b0010), 1,  0,  0);
    run_op("ill18",   6'd18, 3'd5, 16'd1,    16'd2,   -1,  16'd0,    4'b0000, mk(16'd0,    3'd5, 1'b0, 2'b01, 4'b0010), 1,  0,  0);
    run_op("dec17",   6'd17, 3'd6, 16'd1,    16'd0,    3,  16'd0,    4'b1000, mk(16'd0,    3'd6, 1'b1, 2'b00, 4'b1000), 4,  3,  0);
    run_op("div0",    6'd3,  3'd1, 16'h1E,   16'd0,   -1,  16'd0,    4'b0000, mk(16'd0,    3'd1, 1'b0, 2'b10, 4'b1000), 1,  0,  0);
    run_op("mod0",    6'd4,  3'd2, 16'd7,    16'd0,   -1,  16'd0,    4'b0000, mk(16'd0,    3'd2, 1'b0, 2'b10, 4'b1000), 1,  0,  0);
    run_op("timeout", 6'd0,  3'd2, 16'd1,    16'd1,   -1,  16'hBEEF, 4'b0111, mk(16'd0,    3'd2, 1'b0, 2'b11, 4'b1000), 17, 16, 0);
    run_op("lastcyc", 6'd0,  3'd3, 16'h1000, 16'h0234, 16, 16'h1234, 4'b0000, mk(16'h1234, 3'd3, 1'b1, 2'b00, 4'b0000), 17, 16, 0);
    run_op("div3",    6'd3,  3'd4, 16'h1E,   16'd3,    2,  16'd10,   4'b0000, mk(16'd10,   3'd4, 1'b1, 2'b00, 4'b0000), 3,  2,  0);
    run_op("tst",     6'd15, 3'd5, 16'h8000, 16'h8000, 1,  16'h8000, 4'b0100, mk(16'h8000, 3'd5, 1'b0, 2'b00, 4'b0100), 2,  1,  0);
    run_op("stall",   6'd0,  3'd7, 16'h7FFF, 16'd1,    1,  16'h8000, 4'b0101, mk(16'h8000, 3'd7, 1'b1, 2'b00, 4'b0101), 2,  1,  5);

    // Reset in the middle of EXEC: transaction dropped, no response.
    req_valid = 1'b1; req_opcode = 6'd0; req_dst = 3'd1; req_op1 = 16'd9; req_op2 = 16'd9;
    next_cycle();
    req_valid = 1'b0;
    repeat (3) next_cycle();
    check("mid_exec_enable", alu_enable, 1);
    rst_b = 1'b1;
    #1;
    check("rst_async_enable", alu_enable, 0);
    check("rst_async_flags", flags, 0);
    check("rst_async_req_ready", req_ready, 1);
    next_cycle();
    rst_b = 1'b0;
    repeat (2) next_cycle();
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_enable", alu_enable, 0);
    check("post_rst_rsp_error", rsp_error, 0);
    check("post_rst_req_ready", req_ready, 1);

    run_op("recover", 6'd0,  3'd0, 16'd1,    16'd2,    1,  16'd3,    4'b0000, mk(16'd3,    3'd0, 1'b1, 2'b00, 4'b0000), 2,  1,  0);

    next_cycle();
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
